uart_fifo_param: RTL and testbench

Parametrised, synchronous single-clock FIFO that buffers bytes between the UART receiver/transmitter and the rest of the design. It generalises the existing UART FIFO in four ways: configurable data width and depth, an occupancy count output, almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. A synchronous flush input and a selectable first-word-fall-through (FWFT) read mode are also added.

---
 rtl/uart_fifo_param.sv | 95 +++++++++
 tb/tb_uart_fifo_param.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_param.sv
// Parametrised single-clock byte FIFO for the UART paths: occupancy count, threshold flags,
// sticky overflow/underflow errors, synchronous flush and optional first-word fall-through.
module uart_fifo_param #(
    parameter int data_width          = 8,
    parameter int bits_depth          = 2,
    parameter int almost_full_margin  = 1,
    parameter int almost_empty_margin = 1,
    parameter int fwft                = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write_flag,
    input  logic                  read_flag,
    input  logic [data_width-1:0] data_in,
    output logic [data_width-1:0] data_out,
    output logic [bits_depth:0]   count,
    output logic                  empty_flag,
    output logic                  full_flag,
    output logic                  almost_empty_flag,
    output logic                  almost_full_flag,
    output logic                  overflow_flag,
    output logic                  underflow_flag
);

    localparam int depth = 1 << bits_depth;
    localparam logic [bits_depth:0] full_level = (bits_depth+1)'(depth);
    localparam logic [bits_depth:0] af_level   = (bits_depth+1)'(depth - almost_full_margin);
    localparam logic [bits_depth:0] ae_level   = (bits_depth+1)'(almost_empty_margin);

    logic [data_width-1:0] mem [depth];
    logic [bits_depth-1:0] rd_ptr;
    logic [bits_depth-1:0] wr_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  ovf_evt;
    logic                  udf_evt;

    assign empty_flag        = (count == '0);
    assign full_flag         = (count == full_level);
    assign almost_full_flag  = (count >= af_level);
    assign almost_empty_flag = (count <= ae_level);

    assign rd_ok   = read_flag & ~empty_flag;
    assign wr_ok   = write_flag & (~full_flag | rd_ok);
    assign ovf_evt = write_flag & ~wr_ok;
    // In fall-through mode a read+write on an empty FIFO counts as a plain write, not an underflow.
    assign udf_evt = read_flag & empty_flag & ~((fwft != 0) & write_flag);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
        end else if (clear) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_evt) overflow_flag  <= 1'b1;
            if (udf_evt) underflow_flag <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_ok && !clear) mem[wr_ptr] <= data_in;
    end

    generate
        if (fwft != 0) begin : g_fwft
            assign data_out = empty_flag ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [data_width-1:0] dout_q;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)      dout_q <= '0;
                else if (clear)  dout_q <= '0;
                else if (rd_ok)  dout_q <= mem[rd_ptr];
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed bench for uart_fifo_param: a registered-read and a fall-through instance share stimulus.
module tb_uart_fifo_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       write_flag = 1'b0;
    logic       read_flag = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] a_dout, b_dout;
    logic [2:0] a_cnt, b_cnt;
    logic       a_e, a_f, a_ae, a_af, a_ov, a_un;
    logic       b_e, b_f, b_ae, b_af, b_ov, b_un;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    uart_fifo_param #(.data_width(8), .bits_depth(2), .almost_full_margin(1),
                      .almost_empty_margin(1), .fwft(0)) dut_a (
        .clock(clock), .reset(reset), .clear(clear), .write_flag(write_flag),
        .read_flag(read_flag), .data_in(data_in), .data_out(a_dout), .count(a_cnt),
        .empty_flag(a_e), .full_flag(a_f), .almost_empty_flag(a_ae),
        .almost_full_flag(a_af), .overflow_flag(a_ov), .underflow_flag(a_un));

    uart_fifo_param #(.data_width(8), .bits_depth(2), .almost_full_margin(1),
                      .almost_empty_margin(1), .fwft(1)) dut_b (
        .clock(clock), .reset(reset), .clear(clear), .write_flag(write_flag),
        .read_flag(read_flag), .data_in(data_in), .data_out(b_dout), .count(b_cnt),
        .empty_flag(b_e), .full_flag(b_f), .almost_empty_flag(b_ae),
        .almost_full_flag(b_af), .overflow_flag(b_ov), .underflow_flag(b_un));

    typedef struct {
        logic       wr, rd, clr;
        logic [7:0] din;
        logic [7:0] dout;
        logic [2:0] cnt;
        logic [5:0] flags;  // {empty, full, almost_empty, almost_full, overflow, underflow}
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic addv(input logic wr, input logic rd, input logic clr, input logic [7:0] din,
                        input logic [7:0] dout, input logic [2:0] cnt, input logic [5:0] flags);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.dout = dout; v.cnt = cnt; v.flags = flags;
        vecs.push_back(v);
    endtask

    task automatic step(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
        write_flag = wr; read_flag = rd; clear = clr; data_in = din;
        @(posedge clock);
        #1;
        write_flag = 1'b0; read_flag = 1'b0; clear = 1'b0;
    endtask

    task automatic fill_to_three();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h31 + i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        // Scenario 1: fill, threshold flags, overflow
        addv(1,0,0, 8'd1,  8'd0, 3'd1, 6'b001000);
        addv(1,0,0, 8'd2,  8'd0, 3'd2, 6'b000000);
        addv(1,0,0, 8'd3,  8'd0, 3'd3, 6'b000100);
        addv(1,0,0, 8'd4,  8'd0, 3'd4, 6'b010100);
        addv(1,0,0, 8'd5,  8'd0, 3'd4, 6'b010110);
        // Scenario 2: drain, underflow holds data_out
        addv(0,1,0, 8'd0,  8'd1, 3'd3, 6'b000110);
        addv(0,1,0, 8'd0,  8'd2, 3'd2, 6'b000010);
        addv(0,1,0, 8'd0,  8'd3, 3'd1, 6'b001010);
        addv(0,1,0, 8'd0,  8'd4, 3'd0, 6'b101010);
        addv(0,1,0, 8'd0,  8'd4, 3'd0, 6'b101011);
        // Scenario 3: wrap-around with interleaved push/pop
        addv(1,0,0, 8'd10, 8'd4,  3'd1, 6'b001011);
        addv(1,0,0, 8'd11, 8'd4,  3'd2, 6'b000011);
        addv(1,1,0, 8'd12, 8'd10, 3'd2, 6'b000011);
        addv(1,1,0, 8'd13, 8'd11, 3'd2, 6'b000011);
        addv(1,1,0, 8'd14, 8'd12, 3'd2, 6'b000011);
        addv(1,1,0, 8'd15, 8'd13, 3'd2, 6'b000011);
        addv(0,1,0, 8'd0,  8'd14, 3'd1, 6'b001011);
        addv(0,1,0, 8'd0,  8'd15, 3'd0, 6'b101011);
        // Clear with a concurrent write: flushed, write ignored, errors cleared
        addv(1,0,1, 8'd99, 8'd0,  3'd0, 6'b101000);
        // Scenario 4: full plus simultaneous read/write
        addv(1,0,0, 8'd20, 8'd0,  3'd1, 6'b001000);
        addv(1,0,0, 8'd21, 8'd0,  3'd2, 6'b000000);
        addv(1,0,0, 8'd22, 8'd0,  3'd3, 6'b000100);
        addv(1,0,0, 8'd23, 8'd0,  3'd4, 6'b010100);
        addv(1,1,0, 8'd24, 8'd20, 3'd4, 6'b010100);
        addv(0,1,0, 8'd0,  8'd21, 3'd3, 6'b000100);
        addv(0,1,0, 8'd0,  8'd22, 3'd2, 6'b000000);
        addv(0,1,0, 8'd0,  8'd23, 3'd1, 6'b001000);
        addv(0,1,0, 8'd0,  8'd24, 3'd0, 6'b101000);

        repeat (2) @(posedge clock);
        #1;
        chk("rst_dout", 0, 32'(a_dout), 32'h0);
        chk("rst_cnt", 0, 32'(a_cnt), 32'h0);
        chk("rst_flags", 0, 32'({a_e, a_f, a_ae, a_af, a_ov, a_un}), 32'b101000);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            chk("vec_dout", i, 32'(a_dout), 32'(vecs[i].dout));
            chk("vec_cnt", i, 32'(a_cnt), 32'(vecs[i].cnt));
            chk("vec_flags", i, 32'({a_e, a_f, a_ae, a_af, a_ov, a_un}), 32'(vecs[i].flags));
        end

        // Asynchronous reset between edges, mid-operation
        step(1'b1, 1'b0, 1'b1, 8'h00);
        fill_to_three();
        chk("pre_rst_cnt", 0, 32'(a_cnt), 32'd3);
        chk("pre_rst_ovf", 0, 32'(a_ov), 32'd1);
        reset = 1'b0;
        #2;
        chk("async_cnt", 0, 32'(a_cnt), 32'h0);
        chk("async_dout", 0, 32'(a_dout), 32'h0);
        chk("async_flags", 0, 32'({a_e, a_f, a_ae, a_af, a_ov, a_un}), 32'b101000);
        chk("async_b_cnt", 0, 32'(b_cnt), 32'h0);
        chk("async_b_dout", 0, 32'(b_dout), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Scenario 5: fall-through instance
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        chk("fwft_dout", 0, 32'(b_dout), 32'hA5);
        chk("fwft_cnt", 0, 32'(b_cnt), 32'd1);
        chk("fwft_empty", 0, 32'(b_e), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("fwft_empty", 1, 32'(b_e), 32'd1);
        chk("fwft_dout", 1, 32'(b_dout), 32'h0);
        step(1'b1, 1'b1, 1'b0, 8'h5A);
        chk("fwft_cnt", 1, 32'(b_cnt), 32'd1);
        chk("fwft_udf", 0, 32'(b_un), 32'd0);
        chk("fwft_dout", 2, 32'(b_dout), 32'h5A);

        // Clear with a concurrent write from count 3 with overflow set
        step(1'b1, 1'b0, 1'b1, 8'h00);
        fill_to_three();
        chk("pre_clr_cnt", 0, 32'(a_cnt), 32'd3);
        chk("pre_clr_ovf", 0, 32'(a_ov), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'h77);
        chk("clr_cnt", 0, 32'(a_cnt), 32'd0);
        chk("clr_dout", 0, 32'(a_dout), 32'h0);
        chk("clr_flags", 0, 32'({a_e, a_f, a_ae, a_af, a_ov, a_un}), 32'b101000);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("clr_cnt", 1, 32'(a_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
